if_trace_tracker: RTL and testbench

- Sits directly upstream of the trace consumers; watches the core's instruction-fetch memory interface and the IF→ID handoff.
- Builds one ryuki_datatypes::trace_output record per instruction: fetched word, address, IF-stage start/end cycle, memory-access start/end cycle.
- Timestamps come from an internal free-running cycle counter.
- Completed records are queued in a small FIFO and drained over a valid/ready interface.

---
 rtl/if_trace_tracker_pkg.sv | 42 ++++
 rtl/if_trace_tracker_fifo.sv | 63 ++++++
 rtl/if_trace_tracker.sv | 174 +++++++++++++++++
 tb/tb_if_trace_tracker.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_trace_tracker_pkg.sv
// rtl/if_trace_tracker_pkg.sv - ryuki defines/datatypes: trace record, FSM state enum, tracker defaults
`ifndef RYUKI_DEFINES
`define RYUKI_DEFINES
`define DATA_WIDTH 32
`define ADDR_WIDTH 32
`endif

package ryuki_datatypes;

  localparam int TRK_DEPTH    = 4;
  localparam int TRK_TS_WIDTH = 32;

  typedef struct packed {
    logic [`DATA_WIDTH-1:0]  instruction;
    logic [`ADDR_WIDTH-1:0]  addr;
    logic [TRK_TS_WIDTH-1:0] if_start;
    logic [TRK_TS_WIDTH-1:0] if_end;
  } IF_data;

  typedef struct packed {
    logic [TRK_TS_WIDTH-1:0] mem_start;
    logic [TRK_TS_WIDTH-1:0] mem_end;
  } mem_access;

  typedef struct packed {
    logic [`DATA_WIDTH-1:0]  instruction;
    logic [`ADDR_WIDTH-1:0]  addr;
    logic [TRK_TS_WIDTH-1:0] if_start;
    logic [TRK_TS_WIDTH-1:0] if_end;
    logic [TRK_TS_WIDTH-1:0] mem_start;
    logic [TRK_TS_WIDTH-1:0] mem_end;
  } trace_output;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID,
    WAIT_HANDOFF,
    DRAIN
  } if_trk_state_e;

endpackage

// File: rtl/if_trace_tracker_fifo.sv
// rtl/if_trace_tracker_fifo.sv - trace_fifo: record queue accepting push+pop in the same cycle when full
module trace_fifo
  import ryuki_datatypes::*;
#(
  parameter int DEPTH = TRK_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  trace_output push_data,
  input  logic        pop,
  output trace_output pop_data,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  trace_output mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [AW:0]   count;
  logic          wr;
  logic          rd;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  // A pop frees the head slot this cycle, so a full queue may still take a write.
  assign wr = push & (~full | pop);
  assign rd = pop & ~empty;
  // Head is forced to zero while empty so the output reads all-zero after reset.
  assign pop_data = empty ? '0 : mem[rptr];

  // Storage write; contents only become visible through the count-gated head.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (wr) begin
        wptr <= wptr + 1'b1;
      end
      if (rd) begin
        rptr <= rptr + 1'b1;
      end
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_trace_tracker.sv
// rtl/if_trace_tracker.sv - builds per-instruction fetch trace records; IF_TRACE_DROP_COUNT_EN adds dropped_count_o
module if_trace_tracker
  import ryuki_datatypes::*;
#(
  parameter int DEPTH    = TRK_DEPTH,
  parameter int TS_WIDTH = TRK_TS_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_req_i,
  input  logic                   instr_gnt_i,
  input  logic [`ADDR_WIDTH-1:0] instr_addr_i,
  input  logic                   instr_rvalid_i,
  input  logic [`DATA_WIDTH-1:0] instr_rdata_i,
  input  logic                   if_valid_i,
  input  logic                   id_ready_i,
  input  logic                   flush_i,
  output trace_output            trace_o,
  output logic                   trace_valid_o,
  input  logic                   trace_ready_i,
`ifdef IF_TRACE_DROP_COUNT_EN
  output logic [15:0]            dropped_count_o,
`endif
  output logic                   overflow_o
);

  logic [TS_WIDTH-1:0] cnt;
  if_trk_state_e       state;
  if_trk_state_e       state_n;
  trace_output         cap;
  trace_output         cap_n;
  trace_output         push_rec;
  logic                push;
  logic                start;
  logic                handoff;
  logic                pop;
  logic                full;
  logic                empty;
  logic                drop;

  assign handoff = if_valid_i & id_ready_i;

  // Free-running timestamp source; wraps silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // FSM state and in-flight record capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cap   <= '0;
    end else begin
      state <= state_n;
      cap   <= cap_n;
    end
  end

  // Next-state, capture updates and push decision; flush overrides every other event.
  always_comb begin
    state_n         = state;
    cap_n           = cap;
    push            = 1'b0;
    start           = 1'b0;
    push_rec        = cap;
    push_rec.if_end = cnt;
    case (state)
      IDLE: begin
        if (!flush_i && instr_req_i) begin
          start = 1'b1;
        end
      end
      WAIT_GNT: begin
        if (flush_i) begin
          state_n = IDLE;
        end else if (instr_gnt_i) begin
          cap_n.addr = instr_addr_i;
          state_n    = WAIT_RVALID;
        end
      end
      WAIT_RVALID: begin
        if (flush_i) begin
          // The response still owed by memory must be swallowed unless it is arriving now.
          state_n = instr_rvalid_i ? IDLE : DRAIN;
        end else if (instr_rvalid_i) begin
          cap_n.mem_end     = cnt;
          cap_n.instruction = instr_rdata_i;
          if (handoff) begin
            push                 = 1'b1;
            push_rec.mem_end     = cnt;
            push_rec.instruction = instr_rdata_i;
            if (instr_req_i) begin
              start = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end else begin
            state_n = WAIT_HANDOFF;
          end
        end
      end
      WAIT_HANDOFF: begin
        if (flush_i) begin
          state_n = IDLE;
        end else if (handoff) begin
          push = 1'b1;
          if (instr_req_i) begin
            start = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DRAIN: begin
        if (instr_rvalid_i) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // New fetch capture shared by IDLE and the back-to-back paths.
    if (start) begin
      cap_n.if_start  = cnt;
      cap_n.mem_start = cnt;
      if (instr_gnt_i) begin
        cap_n.addr = instr_addr_i;
        state_n    = WAIT_RVALID;
      end else begin
        state_n = WAIT_GNT;
      end
    end
  end

  assign pop  = trace_valid_o & trace_ready_i;
  assign drop = push & full & ~pop;

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_rec),
    .pop       (pop),
    .pop_data  (trace_o),
    .full      (full),
    .empty     (empty)
  );

  assign trace_valid_o = ~empty;

  // Sticky drop indicator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_o <= 1'b0;
    end else if (drop) begin
      overflow_o <= 1'b1;
    end
  end

`ifdef IF_TRACE_DROP_COUNT_EN
  // Saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dropped_count_o <= '0;
    end else if (drop && dropped_count_o != 16'hFFFF) begin
      dropped_count_o <= dropped_count_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_if_trace_tracker.sv
// tb/tb_if_trace_tracker.sv - directed self-checking bench for if_trace_tracker
module tb_if_trace_tracker;
  import ryuki_datatypes::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_req = 1'b0;
  logic        instr_gnt = 1'b0;
  logic [31:0] instr_addr = '0;
  logic        instr_rvalid = 1'b0;
  logic [31:0] instr_rdata = '0;
  logic        if_valid = 1'b0;
  logic        id_ready = 1'b0;
  logic        flush = 1'b0;
  trace_output trace;
  logic        trace_valid;
  logic        trace_ready = 1'b0;
  logic        overflow;
`ifdef IF_TRACE_DROP_COUNT_EN
  logic [15:0] dropped_count;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  if_trace_tracker dut (
    .clk             (clk),
    .rst             (rst),
    .instr_req_i     (instr_req),
    .instr_gnt_i     (instr_gnt),
    .instr_addr_i    (instr_addr),
    .instr_rvalid_i  (instr_rvalid),
    .instr_rdata_i   (instr_rdata),
    .if_valid_i      (if_valid),
    .id_ready_i      (id_ready),
    .flush_i         (flush),
    .trace_o         (trace),
    .trace_valid_o   (trace_valid),
    .trace_ready_i   (trace_ready),
`ifdef IF_TRACE_DROP_COUNT_EN
    .dropped_count_o (dropped_count),
`endif
    .overflow_o      (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input logic [31:0] ins, input logic [31:0] adr,
                         input logic [31:0] ifs, input logic [31:0] ife,
                         input logic [31:0] ms, input logic [31:0] me);
    chk({tag, "_valid"}, {31'b0, trace_valid}, 32'd1);
    chk({tag, "_instr"}, trace.instruction, ins);
    chk({tag, "_addr"}, trace.addr, adr);
    chk({tag, "_if_start"}, trace.if_start, ifs);
    chk({tag, "_if_end"}, trace.if_end, ife);
    chk({tag, "_mem_start"}, trace.mem_start, ms);
    chk({tag, "_mem_end"}, trace.mem_end, me);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic idle_bus();
    instr_req = 1'b0; instr_gnt = 1'b0; instr_rvalid = 1'b0;
    if_valid = 1'b0; id_ready = 1'b0; flush = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, trace_valid}, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    chk("rst_trace_addr", trace.addr, 32'd0);
    chk("rst_trace_instr", trace.instruction, 32'd0);
    rst = 1'b0;
    cyc = 0;

    // Single-cycle grant, rvalid and handoff together.
    goto(5);
    instr_req = 1'b1; instr_gnt = 1'b1; instr_addr = 32'h80;
    step();
    idle_bus();
    step();
    instr_rvalid = 1'b1; instr_rdata = 32'h00A00093; if_valid = 1'b1; id_ready = 1'b1;
    chk("t1_no_bypass", {31'b0, trace_valid}, 32'd0);
    step();
    idle_bus();
    chk_rec("t1", 32'h00A00093, 32'h80, 32'd5, 32'd7, 32'd5, 32'd7);
    trace_ready = 1'b1;
    step();
    trace_ready = 1'b0;
    chk("t1_popped", {31'b0, trace_valid}, 32'd0);

    // Delayed grant and delayed handoff; address must come from the grant cycle.
    goto(10);
    instr_req = 1'b1; instr_addr = 32'hDEAD0000;
    goto(12);
    instr_gnt = 1'b1; instr_addr = 32'h84;
    step();
    idle_bus();
    goto(14);
    instr_rvalid = 1'b1; instr_rdata = 32'h00000013;
    step();
    idle_bus();
    goto(17);
    if_valid = 1'b1; id_ready = 1'b1;
    step();
    idle_bus();
    chk_rec("t2", 32'h00000013, 32'h84, 32'd10, 32'd17, 32'd10, 32'd14);
    trace_ready = 1'b1;
    step();
    trace_ready = 1'b0;

    // Flush while waiting for rvalid: stale response absorbed, nothing recorded.
    goto(20);
    instr_req = 1'b1; instr_gnt = 1'b1; instr_addr = 32'h88;
    step();
    idle_bus();
    flush = 1'b1;
    step();
    idle_bus();
    instr_rvalid = 1'b1; instr_rdata = 32'h0BAD0BAD; if_valid = 1'b1; id_ready = 1'b1;
    step();
    idle_bus();
    instr_req = 1'b1; instr_gnt = 1'b1; instr_addr = 32'h8C;
    chk("t3_no_push_23", {31'b0, trace_valid}, 32'd0);
    step();
    idle_bus();
    chk("t3_no_push_24", {31'b0, trace_valid}, 32'd0);
    step();
    instr_rvalid = 1'b1; instr_rdata = 32'h00108093; if_valid = 1'b1; id_ready = 1'b1;
    step();
    idle_bus();
    chk_rec("t3", 32'h00108093, 32'h8C, 32'd23, 32'd25, 32'd23, 32'd25);
    trace_ready = 1'b1;
    step();
    trace_ready = 1'b0;

    // Five completions with consumer stalled: four queued, fifth dropped.
    goto(30);
    for (int k = 0; k < 5; k++) begin
      instr_req = 1'b1; instr_gnt = 1'b1; instr_addr = 32'h100 + 32'(4 * k);
      step();
      idle_bus();
      instr_rvalid = 1'b1; instr_rdata = 32'h1000 + 32'(k); if_valid = 1'b1; id_ready = 1'b1;
      if (k == 4) begin
        chk("t4_no_overflow_yet", {31'b0, overflow}, 32'd0);
        chk("t4_head_stable", trace.addr, 32'h100);
      end
      step();
      idle_bus();
    end
    chk("t4_overflow", {31'b0, overflow}, 32'd1);
    chk("t4_head", trace.addr, 32'h100);
`ifdef IF_TRACE_DROP_COUNT_EN
    chk("t4_drop_count", {16'b0, dropped_count}, 32'd1);
`endif

    // Full queue: push and pop in the same cycle, no drop.
    instr_req = 1'b1; instr_gnt = 1'b1; instr_addr = 32'h200;
    step();
    idle_bus();
    instr_rvalid = 1'b1; instr_rdata = 32'h2000; if_valid = 1'b1; id_ready = 1'b1;
    trace_ready = 1'b1;
    step();
    idle_bus();
    trace_ready = 1'b0;
    chk("t5_overflow_sticky", {31'b0, overflow}, 32'd1);
`ifdef IF_TRACE_DROP_COUNT_EN
    chk("t5_drop_count", {16'b0, dropped_count}, 32'd1);
`endif
    chk("t5_head0", trace.addr, 32'h104);
    trace_ready = 1'b1;
    step();
    chk("t5_head1", trace.addr, 32'h108);
    chk("t5_head1_instr", trace.instruction, 32'h1002);
    step();
    chk("t5_head2", trace.addr, 32'h10C);
    step();
    chk_rec("t5_new", 32'h2000, 32'h200, 32'd40, 32'd41, 32'd40, 32'd41);
    step();
    trace_ready = 1'b0;
    chk("t5_drained", {31'b0, trace_valid}, 32'd0);

    // Counter wrap between start and end of a record.
    goto(50);
    force dut.cnt = 32'hFFFFFFFE;
    instr_req = 1'b1; instr_gnt = 1'b1; instr_addr = 32'h300;
    #1;
    release dut.cnt;
    step();
    idle_bus();
    step();
    step();
    instr_rvalid = 1'b1; instr_rdata = 32'h3000; if_valid = 1'b1; id_ready = 1'b1;
    step();
    idle_bus();
    chk_rec("t6", 32'h3000, 32'h300, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFE, 32'h1);
    chk("t6_duration", trace.mem_end - trace.mem_start, 32'd3);

    // Asynchronous reset mid-operation clears queue and sticky flag.
    rst = 1'b1;
    #1;
    chk("t7_rst_valid", {31'b0, trace_valid}, 32'd0);
    chk("t7_rst_overflow", {31'b0, overflow}, 32'd0);
    chk("t7_rst_trace", trace.mem_end, 32'd0);
`ifdef IF_TRACE_DROP_COUNT_EN
    chk("t7_rst_drop_count", {16'b0, dropped_count}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
